// File: rtl/imm_operand_encoder.sv
// Packs a 32-bit constant into the ARM {rot4, imm8} immediate form, testing one rotation per clock.
// Define IMM_ENC_MVN_EN to add a second pass over ~value, so constants can be encoded for MVN/CMN/BIC.
module imm_operand_encoder #(
    parameter int ROT_STEPS = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] value,
    input  logic        c_in,
    output logic        busy,
    output logic        done,
    output logic        valid,
    output logic [7:0]  imm8,
    output logic [3:0]  rot4,
    output logic        inv,
    output logic        shift_cout
);

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_SEARCH     = 2'd1;
    localparam logic [1:0] ST_DONE       = 2'd2;
`ifdef IMM_ENC_MVN_EN
    localparam logic [1:0] ST_SEARCH_INV = 2'd3;
`endif
    localparam logic [3:0] LAST_ROT      = 4'(ROT_STEPS - 1);

    logic [1:0]  state;
    logic [31:0] v_reg;
    logic        c_reg;
    logic [3:0]  r;

    logic [4:0]  amt;
    logic [31:0] t;
    logic        hit;
    logic        last;
    logic        hit_cout;

    // Rotating left by 2*r undoes the decoder's rotate right, so a hit leaves the payload in t[7:0].
    // A zero amount shifts the right half by 32, which contributes nothing.
    assign amt      = {r, 1'b0};
    assign t        = (v_reg << amt) | (v_reg >> (6'd32 - {1'b0, amt}));
    assign hit      = (t[31:8] == 24'd0);
    assign last     = (r == LAST_ROT);
    assign hit_cout = (r == 4'd0) ? c_reg : v_reg[31];

`ifdef IMM_ENC_MVN_EN
    assign busy = (state == ST_SEARCH) || (state == ST_SEARCH_INV);
`else
    assign busy = (state == ST_SEARCH);
    assign inv  = 1'b0;
`endif
    assign done = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            v_reg      <= 32'd0;
            c_reg      <= 1'b0;
            r          <= 4'd0;
            valid      <= 1'b0;
            imm8       <= 8'd0;
            rot4       <= 4'd0;
            shift_cout <= 1'b0;
`ifdef IMM_ENC_MVN_EN
            inv        <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        v_reg      <= value;
                        c_reg      <= c_in;
                        r          <= 4'd0;
                        valid      <= 1'b0;
                        imm8       <= 8'd0;
                        rot4       <= 4'd0;
                        shift_cout <= 1'b0;
`ifdef IMM_ENC_MVN_EN
                        inv        <= 1'b0;
`endif
                        state      <= ST_SEARCH;
                    end
                end

                ST_SEARCH: begin
                    if (hit) begin
                        valid      <= 1'b1;
                        imm8       <= t[7:0];
                        rot4       <= r;
                        shift_cout <= hit_cout;
                        state      <= ST_DONE;
                    end else if (last) begin
`ifdef IMM_ENC_MVN_EN
                        // v_reg now carries ~value, so hit_cout still reads bit 31 of the encoded operand.
                        v_reg      <= ~v_reg;
                        r          <= 4'd0;
                        state      <= ST_SEARCH_INV;
`else
                        valid      <= 1'b0;
                        imm8       <= 8'd0;
                        rot4       <= 4'd0;
                        shift_cout <= c_reg;
                        state      <= ST_DONE;
`endif
                    end else begin
                        r <= r + 4'd1;
                    end
                end

`ifdef IMM_ENC_MVN_EN
                ST_SEARCH_INV: begin
                    if (hit) begin
                        valid      <= 1'b1;
                        inv        <= 1'b1;
                        imm8       <= t[7:0];
                        rot4       <= r;
                        shift_cout <= hit_cout;
                        state      <= ST_DONE;
                    end else if (last) begin
                        valid      <= 1'b0;
                        inv        <= 1'b0;
                        imm8       <= 8'd0;
                        rot4       <= 4'd0;
                        shift_cout <= c_reg;
                        state      <= ST_DONE;
                    end else begin
                        r <= r + 4'd1;
                    end
                end
`endif

                ST_DONE: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imm_operand_encoder.sv
// Self-checking bench for imm_operand_encoder: directed table, hand sequences, randomized vectors vs a brute-force model.
`timescale 1ns/1ps
module tb_imm_operand_encoder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] value = 32'd0;
    logic        c_in = 1'b0;
    logic        busy, done, valid, inv, shift_cout;
    logic [7:0]  imm8;
    logic [3:0]  rot4;

    int total = 0;
    int bad = 0;

`ifdef IMM_ENC_MVN_EN
    localparam int NPASS = 2;
    localparam int FAIL_CYC = 33;
`else
    localparam int NPASS = 1;
    localparam int FAIL_CYC = 17;
`endif

    typedef struct {
        logic       valid;
        logic [7:0] imm8;
        logic [3:0] rot4;
        logic       inv;
        logic       sc;
        int         cyc;
    } res_t;

    typedef struct {
        logic [31:0] value;
        logic        c;
        res_t        exp;
    } vec_t;

    imm_operand_encoder dut (
        .clk(clk), .reset_n(reset_n), .start(start), .value(value), .c_in(c_in),
        .busy(busy), .done(done), .valid(valid), .imm8(imm8), .rot4(rot4),
        .inv(inv), .shift_cout(shift_cout)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] ror32(input logic [31:0] x, input int amt);
        logic [63:0] d;
        d = {x, x} >> amt;
        return d[31:0];
    endfunction

    // Reference: search every (rot, imm8) pair the decoder could expand and keep the smallest rot.
    function automatic res_t model(input logic [31:0] v, input logic c);
        res_t m;
        logic [31:0] target;
        m.valid = 1'b0; m.imm8 = 8'd0; m.rot4 = 4'd0; m.inv = 1'b0; m.sc = c; m.cyc = FAIL_CYC;
        for (int pass = 0; pass < NPASS && !m.valid; pass++) begin
            target = (pass == 1) ? ~v : v;
            for (int rr = 0; rr < 16 && !m.valid; rr++) begin
                for (int i = 0; i < 256 && !m.valid; i++) begin
                    if (ror32(32'(i), 2 * rr) == target) begin
                        m.valid = 1'b1;
                        m.imm8  = 8'(i);
                        m.rot4  = 4'(rr);
                        m.inv   = (pass == 1);
                        m.sc    = (rr == 0) ? c : target[31];
                        m.cyc   = (pass == 1) ? rr + 18 : rr + 2;
                    end
                end
            end
        end
        return m;
    endfunction

    task automatic applyStimulus(input logic [31:0] v, input logic c, output res_t got);
        int n;
        logic busy_ok;
        @(negedge clk);
        value = v; c_in = c; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; value = $urandom; c_in = 1'($urandom);
        n = 1; busy_ok = 1'b1;
        while (!done && n < 40) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        checkVal("busy_during_search", 32'(busy_ok), 32'd1);
        got.cyc   = done ? n : -1;
        got.valid = valid; got.imm8 = imm8; got.rot4 = rot4; got.inv = inv; got.sc = shift_cout;
        checkVal("busy_low_at_done", 32'(busy), 32'd0);
        @(posedge clk); #1;
        checkVal("done_one_cycle", 32'(done), 32'd0);
    endtask

    task automatic checkOutput(input string tag, input res_t got, input res_t exp);
        checkVal({tag, ".done_cycle"}, 32'(got.cyc), 32'(exp.cyc));
        checkVal({tag, ".valid"}, 32'(got.valid), 32'(exp.valid));
        checkVal({tag, ".imm8"}, 32'(got.imm8), 32'(exp.imm8));
        checkVal({tag, ".rot4"}, 32'(got.rot4), 32'(exp.rot4));
        checkVal({tag, ".inv"}, 32'(got.inv), 32'(exp.inv));
        checkVal({tag, ".shift_cout"}, 32'(got.sc), 32'(exp.sc));
    endtask

    task automatic checkAllZero(input string tag);
        checkVal({tag, ".busy"}, 32'(busy), 32'd0);
        checkVal({tag, ".done"}, 32'(done), 32'd0);
        checkVal({tag, ".valid"}, 32'(valid), 32'd0);
        checkVal({tag, ".imm8"}, 32'(imm8), 32'd0);
        checkVal({tag, ".rot4"}, 32'(rot4), 32'd0);
        checkVal({tag, ".inv"}, 32'(inv), 32'd0);
        checkVal({tag, ".shift_cout"}, 32'(shift_cout), 32'd0);
    endtask

    vec_t vecs[8];
    res_t got;
    res_t exp;

    initial begin
        vecs[0] = '{32'h000000FF, 1'b1, '{1'b1, 8'hFF, 4'd0, 1'b0, 1'b1, 2}};
        vecs[1] = '{32'hF000000F, 1'b0, '{1'b1, 8'hFF, 4'd2, 1'b0, 1'b1, 4}};
        vecs[2] = '{32'h00000102, 1'b1, '{1'b0, 8'h00, 4'd0, 1'b0, 1'b1, FAIL_CYC}};
`ifdef IMM_ENC_MVN_EN
        vecs[3] = '{32'hFFFFFF00, 1'b1, '{1'b1, 8'hFF, 4'd0, 1'b1, 1'b1, 18}};
`else
        vecs[3] = '{32'hFFFFFF00, 1'b1, '{1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 17}};
`endif
        vecs[4] = '{32'h00000000, 1'b0, '{1'b1, 8'h00, 4'd0, 1'b0, 1'b0, 2}};
        vecs[5] = '{32'hFF000000, 1'b0, '{1'b1, 8'hFF, 4'd4, 1'b0, 1'b1, 6}};
        vecs[6] = '{32'h000003FC, 1'b1, '{1'b1, 8'hFF, 4'd15, 1'b0, 1'b0, 17}};
        vecs[7] = '{32'h80000000, 1'b0, '{1'b1, 8'h02, 4'd1, 1'b0, 1'b1, 3}};

        // Reset held with start high: reset must win.
        reset_n = 1'b0; start = 1'b1; value = 32'h000000FF; c_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkAllZero("reset");
        start = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].value, vecs[i].c, got);
            checkOutput($sformatf("vec%0d", i), got, vecs[i].exp);
        end

        // Second start during busy is dropped.
        begin
            int n;
            int extra;
            @(negedge clk);
            value = 32'hFF000000; c_in = 1'b0; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0; n = 1;
            @(posedge clk); #1;
            n = 2; start = 1'b1; value = 32'h000000FF;
            @(posedge clk); #1;
            n = 3; start = 1'b0;
            while (!done && n < 40) begin
                @(posedge clk); #1;
                n++;
            end
            checkVal("ignored_start.done_cycle", 32'(n), 32'd6);
            checkVal("ignored_start.imm8", 32'(imm8), 32'hFF);
            checkVal("ignored_start.rot4", 32'(rot4), 32'd4);
            extra = 0;
            repeat (30) begin
                @(posedge clk); #1;
                if (done) extra++;
            end
            checkVal("ignored_start.extra_done", 32'(extra), 32'd0);
        end

        // Reset mid-search aborts silently, then a fresh request works.
        begin
            int saw;
            @(negedge clk);
            value = 32'h00000102; c_in = 1'b1; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            repeat (4) @(posedge clk);
            #1;
            checkVal("abort.busy_before_reset", 32'(busy), 32'd1);
            reset_n = 1'b0;
            @(posedge clk); #1;
            checkAllZero("abort");
            reset_n = 1'b1;
            saw = 0;
            repeat (40) begin
                @(posedge clk); #1;
                if (done) saw++;
            end
            checkVal("abort.no_done", 32'(saw), 32'd0);
            applyStimulus(32'h000000FF, 1'b1, got);
            checkOutput("after_abort", got, vecs[0].exp);
        end

        // start held high re-triggers in the first IDLE cycle after done.
        begin
            int d1, d2;
            d1 = -1; d2 = -1;
            @(negedge clk);
            value = 32'h000000FF; c_in = 1'b1; start = 1'b1;
            @(posedge clk); #1;
            for (int n = 1; n <= 8; n++) begin
                if (done) begin
                    if (d1 < 0) d1 = n;
                    else if (d2 < 0) d2 = n;
                end
                if (n < 8) begin
                    @(posedge clk); #1;
                end
            end
            start = 1'b0;
            checkVal("held_start.first_done", 32'(d1), 32'd2);
            checkVal("held_start.second_done", 32'(d2), 32'd5);
            repeat (40) @(posedge clk);
        end

        // Randomized vectors, biased toward encodable values.
        for (int k = 0; k < 150; k++) begin
            logic [31:0] v;
            logic        c;
            int          sel;
            int          ib;
            int          rb;
            sel = int'($urandom_range(0, 3));
            ib  = int'($urandom_range(0, 255));
            rb  = int'($urandom_range(0, 15));
            c   = 1'($urandom);
            case (sel)
                0:       v = $urandom;
                1:       v = ror32(32'(ib), 2 * rb);
                2:       v = ~ror32(32'(ib), 2 * rb);
                default: v = ror32(32'(ib), int'($urandom_range(0, 31)));
            endcase
            exp = model(v, c);
            applyStimulus(v, c, got);
            checkOutput($sformatf("rand%0d_%08h", k, v), got, exp);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
